// File: rtl/dsp_frame_loader_pkg.sv
// dsp_frame_loader_pkg
//   Shared definitions for the DSP supertile column frame loader:
//   - state_t: loader FSM states
//   - header field positions (END flag, frame index field)
//   - width of the frames_written counter
//   - small helpers mapping a state to its registered status outputs
package dsp_frame_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_STROBE,
        ST_HOLD,
        ST_DONE,
        ST_ERROR
    } state_t;

    // Frame index lives in the low byte of a header word.
    localparam int HDR_IDX_LSB = 0;
    localparam int HDR_IDX_W   = 8;

    // Saturating strobe counter width.
    localparam int FRAMES_WRITTEN_W = 8;

    // END flag is the MSB of the header word, whatever the word width.
    function automatic int hdr_end_pos(input int word_bits);
        return word_bits - 1;
    endfunction

    // States in which the loader takes words from the stream. ERROR keeps
    // accepting (and dropping) words so the bitstream source never stalls.
    function automatic logic ready_in(input state_t s);
        return (s == ST_IDLE) || (s == ST_DATA) || (s == ST_ERROR);
    endfunction

    // States in which a frame is in flight.
    function automatic logic busy_in(input state_t s);
        return (s == ST_DATA) || (s == ST_STROBE) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// frame_strobe_decoder
//   Registered frame index -> one-hot strobe decoder. The output is a single
//   cycle pulse on the clock after en is sampled high; it is all-zero for an
//   index outside 0..NumStrobes-1.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high
//   en     : request a strobe for idx on the next cycle
//   idx    : frame index
//   strobe : one-hot (or zero) registered strobe vector
module frame_strobe_decoder #(
    parameter int NumStrobes = 20,
    parameter int IdxW       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [IdxW-1:0]       idx,
    output logic [NumStrobes-1:0] strobe
);

    always_ff @(posedge clk) begin
        if (reset) begin
            strobe <= '0;
        end else begin
            // Compare against every legal index rather than shifting, so an
            // out-of-range idx simply matches nothing.
            for (int i = 0; i < NumStrobes; i++) begin
                strobe[i] <= en && (idx == IdxW'(i));
            end
        end
    end

endmodule

// File: rtl/dsp_frame_loader.sv
// dsp_frame_loader
//   Configuration sequencer for the two-row DSP supertile column. Takes a
//   valid/ready word stream (header, then one word per tile row), assembles
//   the rows into FrameData and fires a one-cycle one-hot FrameStrobe to
//   latch the frame into the DSP tiles.
//
//   Header word: bit FrameBitsPerRow-1 = END, bits [7:0] = frame index.
//
// Ports:
//   UserCLK        : clock
//   reset          : synchronous, active-high; discards any partial frame
//   s_valid/s_ready/s_data : configuration word stream
//   clear          : leave DONE/ERROR back to IDLE (ignored elsewhere)
//   FrameData      : row r at [r*FrameBitsPerRow +: FrameBitsPerRow]
//   FrameStrobe    : one-hot frame write pulse
//   busy           : frame in progress (DATA/STROBE/HOLD)
//   done           : END header received
//   err            : sticky error (bad index, or incomplete config with mask)
//   frames_written : saturating count of strobes issued
//   frames_mask    : frames strobed since reset/clear
//                    (only with DSP_FRAME_LOADER_MASK_EN defined)
//
// Build option: define DSP_FRAME_LOADER_MASK_EN to add frames_mask and flag
// an END header that arrives before every frame was written.
module dsp_frame_loader
    import dsp_frame_loader_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 2
) (
    input  logic                                UserCLK,
    input  logic                                reset,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [FrameBitsPerRow-1:0]          s_data,
    input  logic                                clear,
    output logic [NumRows*FrameBitsPerRow-1:0]  FrameData,
    output logic [MaxFramesPerCol-1:0]          FrameStrobe,
    output logic                                busy,
    output logic                                done,
    output logic                                err,
    output logic [FRAMES_WRITTEN_W-1:0]         frames_written
`ifdef DSP_FRAME_LOADER_MASK_EN
    ,
    output logic [MaxFramesPerCol-1:0]          frames_mask
`endif
);

    localparam int             RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int             EndPos  = hdr_end_pos(FrameBitsPerRow);
    localparam logic [RowW-1:0] LastRow = RowW'(NumRows - 1);

    state_t                                   state;
    state_t                                   state_next;
    logic [HDR_IDX_W-1:0]                     frame_idx;
    logic [RowW-1:0]                          row_cnt;
    logic [NumRows-1:0][FrameBitsPerRow-1:0]  frame_rows;

    logic                 accept;
    logic                 hdr_end;
    logic                 hdr_bad;
    logic [HDR_IDX_W-1:0] hdr_idx;
    logic                 last_row;
    logic                 strobe_en;
    logic                 leave_idle_clear;
    logic                 end_err;

    assign accept    = s_valid & s_ready;
    assign hdr_end   = s_data[EndPos];
    assign hdr_idx   = s_data[HDR_IDX_LSB +: HDR_IDX_W];
    assign hdr_bad   = int'(hdr_idx) >= MaxFramesPerCol;
    assign last_row  = (row_cnt == LastRow);

    // Fires on the edge that takes the final row, so the registered strobe
    // lines up with the cycle the FSM spends in STROBE.
    assign strobe_en = (state == ST_DATA) && accept && last_row;

    // clear only has an effect from the two terminal states.
    assign leave_idle_clear = clear && ((state == ST_DONE) || (state == ST_ERROR));

    assign FrameData = frame_rows;

`ifdef DSP_FRAME_LOADER_MASK_EN
    logic [MaxFramesPerCol-1:0] mask_q;

    assign frames_mask = mask_q;
    // An END before every frame has been strobed marks the config incomplete.
    assign end_err     = ~&mask_q;

    always_ff @(posedge UserCLK) begin
        if (reset || leave_idle_clear) begin
            mask_q <= '0;
        end else begin
            for (int i = 0; i < MaxFramesPerCol; i++) begin
                if (strobe_en && (frame_idx == HDR_IDX_W'(i))) begin
                    mask_q[i] <= 1'b1;
                end
            end
        end
    end
`else
    assign end_err = 1'b0;
`endif

    // NOTE: state_next gets its default before the case so every path assigns
    // it; a missing default here would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (hdr_end)      state_next = ST_DONE;
                    else if (hdr_bad) state_next = ST_ERROR;
                    else              state_next = ST_DATA;
                end
            end
            ST_DATA:   if (accept && last_row) state_next = ST_STROBE;
            ST_STROBE: state_next = ST_HOLD;
            ST_HOLD:   state_next = ST_IDLE;
            ST_DONE:   if (clear) state_next = ST_IDLE;
            ST_ERROR:  if (clear) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // NOTE: all state updates below are non-blocking so every register sees
    // the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge UserCLK) begin
        if (reset) begin
            state          <= ST_IDLE;
            s_ready        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            frame_idx      <= '0;
            row_cnt        <= '0;
            frames_written <= '0;
            // NOTE: the row registers are reset because they drive FrameData
            // directly and the tiles must see zero after reset.
            frame_rows     <= '0;
        end else begin
            state   <= state_next;
            // Status outputs are registered from the next state so they are
            // valid in the same cycle the FSM occupies that state.
            s_ready <= ready_in(state_next);
            busy    <= busy_in(state_next);
            done    <= (state_next == ST_DONE);

            if ((state == ST_IDLE) && accept && !hdr_end && !hdr_bad) begin
                frame_idx <= hdr_idx;
                row_cnt   <= '0;
            end

            if ((state == ST_DATA) && accept) begin
                frame_rows[row_cnt] <= s_data;
                row_cnt             <= row_cnt + 1'b1;
            end

            if (leave_idle_clear) begin
                err <= 1'b0;
            end else if ((state == ST_IDLE) && accept && (hdr_end ? end_err : hdr_bad)) begin
                err <= 1'b1;
            end

            if (strobe_en && (frames_written != '1)) begin
                frames_written <= frames_written + 1'b1;
            end
        end
    end

    frame_strobe_decoder #(
        .NumStrobes (MaxFramesPerCol),
        .IdxW       (HDR_IDX_W)
    ) u_strobe_dec (
        .clk    (UserCLK),
        .reset  (reset),
        .en     (strobe_en),
        .idx    (frame_idx),
        .strobe (FrameStrobe)
    );

endmodule

// File: tb/tb_dsp_frame_loader.sv
// tb_dsp_frame_loader
//   Directed bench for dsp_frame_loader with default parameters. Inputs are
//   driven and outputs sampled on the falling edge of UserCLK.
//   Build with DSP_FRAME_LOADER_MASK_EN defined to cover frames_mask.
module tb_dsp_frame_loader;

    logic        UserCLK;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        clear;
    logic [63:0] FrameData;
    logic [19:0] FrameStrobe;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  frames_written;
`ifdef DSP_FRAME_LOADER_MASK_EN
    logic [19:0] frames_mask;
`endif

    int          vectors;
    int          miscompares;
    int          cyc;
    int          last_accept_cyc;
    logic [7:0]  exp_fw;
    logic [63:0] exp_data;

    dsp_frame_loader #(
        .MaxFramesPerCol (20),
        .FrameBitsPerRow (32),
        .NumRows         (2)
    ) dut (
        .UserCLK        (UserCLK),
        .reset          (reset),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .clear          (clear),
        .FrameData      (FrameData),
        .FrameStrobe    (FrameStrobe),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .frames_written (frames_written)
`ifdef DSP_FRAME_LOADER_MASK_EN
        ,
        .frames_mask    (frames_mask)
`endif
    );

    initial UserCLK = 1'b0;
    always #5 UserCLK = ~UserCLK;

    initial cyc = 0;
    always @(posedge UserCLK) cyc <= cyc + 1;

    // Present w from the current falling edge and hold it until it transfers.
    // Returns on the falling edge after the accepting rising edge, with
    // s_valid still high.
    task automatic send_word(input logic [31:0] w);
        int n;
        n       = 0;
        s_valid = 1'b1;
        s_data  = w;
        while (!s_ready && n < 64) begin
            @(negedge UserCLK);
            n++;
        end
        if (!s_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: s_ready=%b required 1 for word %h", s_ready, w);
        end else begin
            @(negedge UserCLK);
            last_accept_cyc = cyc;
        end
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        clear   = 1'b0;
        repeat (3) @(negedge UserCLK);
        vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b want 0", s_ready); end
        vectors++; if (FrameData !== 64'h0) begin miscompares++; $display("FAIL rst_data: got %h want 0", FrameData); end
        vectors++; if (FrameStrobe !== 20'h0) begin miscompares++; $display("FAIL rst_strobe: got %h want 0", FrameStrobe); end
        vectors++; if ({busy, done, err} !== 3'b000) begin miscompares++; $display("FAIL rst_flags: busy/done/err got %b want 000", {busy, done, err}); end
        vectors++; if (frames_written !== 8'd0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", frames_written); end
        reset = 1'b0;
        @(negedge UserCLK);
        vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL idle_ready: got %b want 1", s_ready); end
        exp_fw   = 8'd0;
        exp_data = 64'h0;
    endtask

    task automatic test_single_frame;
        int hdr_cyc;
        send_word(32'h0000_0005);
        hdr_cyc = last_accept_cyc;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b want 1", busy); end
        send_word(32'hDEAD_BEEF);
        vectors++; if (FrameStrobe !== 20'h0) begin miscompares++; $display("FAIL single_early_strobe: got %h want 0", FrameStrobe); end
        send_word(32'h1234_5678);
        // Strobe is the cycle that ends at rising edge H+3.
        vectors++; if (FrameStrobe !== 20'h00020) begin miscompares++; $display("FAIL single_strobe: got %h want 00020", FrameStrobe); end
        vectors++; if (cyc - hdr_cyc !== 2) begin miscompares++; $display("FAIL single_latency: got %0d edges after header want 2", cyc - hdr_cyc); end
        vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL single_strobe_ready: got %b want 0", s_ready); end
        vectors++; if (FrameData !== 64'h1234_5678_DEAD_BEEF) begin miscompares++; $display("FAIL single_data: got %h want 12345678deadbeef", FrameData); end
        vectors++; if (frames_written !== 8'd1) begin miscompares++; $display("FAIL single_count: got %0d want 1", frames_written); end
        s_valid = 1'b0;
        @(negedge UserCLK);
        vectors++; if (FrameStrobe !== 20'h0) begin miscompares++; $display("FAIL single_strobe_width: got %h want 0", FrameStrobe); end
        vectors++; if (FrameData !== 64'h1234_5678_DEAD_BEEF) begin miscompares++; $display("FAIL hold_data: got %h want 12345678deadbeef", FrameData); end
        @(negedge UserCLK);
        vectors++; if ({s_ready, busy} !== 2'b10) begin miscompares++; $display("FAIL single_idle: ready/busy got %b want 10", {s_ready, busy}); end
        exp_fw   = 8'd1;
        exp_data = 64'h1234_5678_DEAD_BEEF;
    endtask

    task automatic test_back_to_back;
        int          prev_cyc;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [19:0] exp_strobe;
        prev_cyc = 0;
        for (int f = 0; f < 20; f++) begin
            d0 = 32'hA000_0000 | 32'(f);
            d1 = 32'h5000_0000 | 32'(f * 3);
            exp_strobe = 20'd1 << f;
            send_word(32'(f));
            send_word(d0);
            send_word(d1);
            vectors++; if (FrameStrobe !== exp_strobe) begin miscompares++; $display("FAIL b2b_strobe[%0d]: got %h want %h", f, FrameStrobe, exp_strobe); end
            vectors++; if (FrameData !== {d1, d0}) begin miscompares++; $display("FAIL b2b_data[%0d]: got %h want %h", f, FrameData, {d1, d0}); end
            if (f > 0) begin
                vectors++; if (cyc - prev_cyc !== 5) begin miscompares++; $display("FAIL b2b_period[%0d]: got %0d cycles want 5", f, cyc - prev_cyc); end
            end
            prev_cyc = cyc;
            exp_fw++;
        end
        s_valid  = 1'b0;
        exp_data = {32'h5000_0000 | 32'd57, 32'hA000_0013};
        vectors++; if (frames_written !== exp_fw) begin miscompares++; $display("FAIL b2b_count: got %0d want %0d", frames_written, exp_fw); end
        repeat (2) @(negedge UserCLK);
    endtask

    task automatic test_out_of_range;
        send_word(32'h0000_0014);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL oor_err: got %b want 1", err); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL oor_busy: got %b want 0", busy); end
        send_word(32'h1111_1111);
        vectors++; if (FrameStrobe !== 20'h0) begin miscompares++; $display("FAIL oor_strobe0: got %h want 0", FrameStrobe); end
        send_word(32'h2222_2222);
        vectors++; if (FrameStrobe !== 20'h0) begin miscompares++; $display("FAIL oor_strobe1: got %h want 0", FrameStrobe); end
        vectors++; if (FrameData !== exp_data) begin miscompares++; $display("FAIL oor_data: got %h want %h", FrameData, exp_data); end
        vectors++; if ({err, s_ready} !== 2'b11) begin miscompares++; $display("FAIL oor_sticky: err/ready got %b want 11", {err, s_ready}); end
        vectors++; if (frames_written !== exp_fw) begin miscompares++; $display("FAIL oor_count: got %0d want %0d", frames_written, exp_fw); end
        s_valid = 1'b0;
        clear   = 1'b1;
        @(negedge UserCLK);
        clear = 1'b0;
        vectors++; if ({err, done, s_ready} !== 3'b001) begin miscompares++; $display("FAIL oor_clear: err/done/ready got %b want 001", {err, done, s_ready}); end
    endtask

    task automatic test_mid_frame_reset;
        logic seen;
        send_word(32'h0000_0007);
        send_word(32'hCAFE_F00D);
        s_valid = 1'b0;
        reset   = 1'b1;
        @(negedge UserCLK);
        vectors++; if (FrameData !== 64'h0) begin miscompares++; $display("FAIL mrst_data: got %h want 0", FrameData); end
        vectors++; if ({s_ready, busy, done, err} !== 4'b0000) begin miscompares++; $display("FAIL mrst_flags: ready/busy/done/err got %b want 0000", {s_ready, busy, done, err}); end
        vectors++; if (frames_written !== 8'd0) begin miscompares++; $display("FAIL mrst_count: got %0d want 0", frames_written); end
        vectors++; if (FrameStrobe !== 20'h0) begin miscompares++; $display("FAIL mrst_strobe: got %h want 0", FrameStrobe); end
        reset = 1'b0;
        seen  = 1'b0;
        repeat (10) begin
            @(negedge UserCLK);
            if (FrameStrobe !== 20'h0) seen = 1'b1;
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL mrst_no_strobe: strobe seen=%b want 0", seen); end
        exp_fw   = 8'd0;
        exp_data = 64'h0;
    endtask

    task automatic test_end_header;
        logic exp_err;
`ifdef DSP_FRAME_LOADER_MASK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        send_word(32'h0000_0003);
        send_word(32'h0303_0303);
        send_word(32'h3030_3030);
        vectors++; if (FrameStrobe !== 20'h00008) begin miscompares++; $display("FAIL end_pre_strobe: got %h want 00008", FrameStrobe); end
        exp_fw = 8'd1;
        send_word(32'h8000_0000);
        s_valid = 1'b0;
        vectors++; if ({done, s_ready, busy} !== 3'b100) begin miscompares++; $display("FAIL end_done: done/ready/busy got %b want 100", {done, s_ready, busy}); end
        vectors++; if (err !== exp_err) begin miscompares++; $display("FAIL end_err: got %b want %b", err, exp_err); end
`ifdef DSP_FRAME_LOADER_MASK_EN
        vectors++; if (frames_mask !== 20'h00008) begin miscompares++; $display("FAIL end_mask: got %h want 00008", frames_mask); end
`endif
        repeat (3) @(negedge UserCLK);
        vectors++; if ({done, s_ready} !== 2'b10) begin miscompares++; $display("FAIL end_stay: done/ready got %b want 10", {done, s_ready}); end
        clear = 1'b1;
        @(negedge UserCLK);
        clear = 1'b0;
        vectors++; if ({done, s_ready, err} !== 3'b010) begin miscompares++; $display("FAIL end_clear: done/ready/err got %b want 010", {done, s_ready, err}); end
        vectors++; if (frames_written !== exp_fw) begin miscompares++; $display("FAIL end_count: got %0d want %0d", frames_written, exp_fw); end
`ifdef DSP_FRAME_LOADER_MASK_EN
        vectors++; if (frames_mask !== 20'h0) begin miscompares++; $display("FAIL end_mask_clear: got %h want 0", frames_mask); end
`endif
    endtask

    task automatic test_random_gaps;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [19:0] exp_strobe;
        int          f;
        for (int k = 0; k < 100; k++) begin
            f  = k % 20;
            w0 = $urandom;
            w1 = $urandom;
            exp_strobe = 20'd1 << f;
            s_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge UserCLK);
            send_word(32'(f));
            s_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge UserCLK);
            send_word(w0);
            s_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge UserCLK);
            send_word(w1);
            if (exp_fw != 8'hFF) exp_fw++;
            vectors++; if (FrameStrobe !== exp_strobe) begin miscompares++; $display("FAIL rnd_strobe[%0d]: got %h want %h", k, FrameStrobe, exp_strobe); end
            vectors++; if (FrameData !== {w1, w0}) begin miscompares++; $display("FAIL rnd_data[%0d]: got %h want %h", k, FrameData, {w1, w0}); end
            vectors++; if (frames_written !== exp_fw) begin miscompares++; $display("FAIL rnd_count[%0d]: got %0d want %0d", k, frames_written, exp_fw); end
        end
        s_valid = 1'b0;
        repeat (3) @(negedge UserCLK);
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        last_accept_cyc = 0;
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_out_of_range;
        test_mid_frame_reset;
        test_end_header;
        test_random_gaps;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dsp_frame_loader.md
# dsp_frame_loader

Configuration sequencer for the two-row DSP supertile column. Accepts a valid/ready word stream from the fabric configuration port, assembles one frame's worth of data per tile row, and drives the column's `FrameData` rows plus a one-cycle one-hot `FrameStrobe` pulse to latch that frame into the DSP top and bottom tiles. It sits between the bitstream source and the bottom tile's `FrameStrobe`/`FrameData` inputs.

## Interface
**Parameters**
- `MaxFramesPerCol`, 20: number of frame strobes; valid frame indices are 0..MaxFramesPerCol-1.
- `FrameBitsPerRow`, 32: bits per row; also the stream word width.
- `NumRows`, 2: tile rows fed. Row 0 = top tile X0Y0, row 1 = bottom tile X0Y1.

**Ports**
- `UserCLK` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `s_valid` in 1: stream word valid.
- `s_ready` out 1: loader accepts a word.
- `s_data` in FrameBitsPerRow: header or row data word.
- `clear` in 1: leave DONE or ERROR and return to IDLE.
- `FrameData` out NumRows*FrameBitsPerRow: row r occupies bits [r*FrameBitsPerRow +: FrameBitsPerRow].
- `FrameStrobe` out MaxFramesPerCol: one-hot write pulse.
- `busy` out 1: a frame is in progress (DATA, STROBE or HOLD).
- `done` out 1: end-of-config header received.
- `err` out 1: sticky error, cleared by `reset`/`clear`.
- `frames_written` out 8: count of strobes issued, saturating at 255.

## Operation
- Header word layout:
  - bit FrameBitsPerRow-1 = END flag.
  - bits [7:0] = frame index; all other bits ignored.
- FSM states: IDLE, DATA, STROBE, HOLD, DONE, ERROR.
- **IDLE**: `s_ready`=1. On an accepted header:
  - END=1 → DONE.
  - Index ≥ MaxFramesPerCol → ERROR; `err`=1.
  - Otherwise latch the index, row counter=0, go to DATA.
- **DATA**: `s_ready`=1. Each accepted word is written to row register [row counter], and the counter increments. When row NumRows-1 is accepted → STROBE.
- **STROBE**: `s_ready`=0. `FrameStrobe[idx]`=1 for exactly one cycle; `frames_written` increments. → HOLD.
- **HOLD**: `s_ready`=0, strobe 0, `FrameData` unchanged. → IDLE.
- **DONE**: `s_ready`=0, `done`=1. `clear` → IDLE and `done` drops.
- **ERROR**: `s_ready`=1, and words are accepted and discarded, so the upstream never stalls. `clear` → IDLE and `err` drops.
- `FrameData` changes only on accepted DATA words. It is never modified during STROBE or HOLD.
- `FrameStrobe` is never multi-hot and is never asserted outside STROBE.
- `clear` in IDLE, DATA, STROBE or HOLD is ignored.
- `reset` has priority over everything. It also applies mid-frame: the partial frame is discarded and no strobe is issued.

## Timing
- Reset values:
  - `s_ready`=0 during reset, 1 in the first IDLE cycle after.
  - `FrameData`=0, `FrameStrobe`=0, `busy`=0, `done`=0, `err`=0, `frames_written`=0.
- Handshake: a word transfers on a rising edge with `s_valid`&`s_ready`. `s_ready` is a registered function of state only, with no combinational dependence on `s_valid`.
- Latency (header accepted at cycle H, data words back-to-back):
  - Last row accepted at H+NumRows.
  - Strobe high at H+NumRows+1.
  - HOLD at H+NumRows+2.
  - Next header accepted no earlier than H+NumRows+3.
- Sustained throughput: NumRows+3 cycles per frame.
- `FrameData` row r is valid from the cycle after its word is accepted, and is stable from that point through HOLD.
- All outputs are registered.

## Configuration
- `DSP_FRAME_LOADER_MASK_EN` defined:
  - Adds output `frames_mask` [MaxFramesPerCol-1:0]. Its bit is set when a frame's strobe issues; it is cleared by `reset`/`clear`.
  - An END header with the mask not all-ones sets `err`=1 in addition to entering DONE.
  - Writing an already-set frame is allowed and does not flag an error.
- Undefined: no `frames_mask` port, and END never sets `err`.

## Structure
- Package `dsp_frame_loader_pkg` holds:
  - The state enum.
  - Header field constants: END bit position, index LSB/width.
  - The `frames_written` width.
- Sub-module `frame_strobe_decoder`: registered index → one-hot decoder with an enable input. It outputs all-zero for an out-of-range index.

## Test plan
- Single frame, default parameters:
  - Stimulus: header 0x00000005, then 0xDEADBEEF, 0x12345678.
  - Required: `FrameData`=0x12345678_DEADBEEF; `FrameStrobe`=20'h00020 for one cycle, 3 cycles after the header; `frames_written`=1.
- Back-to-back frames 0..19 with `s_valid` held high:
  - Required: each strobe one-hot in order; exactly 5 cycles per frame; `frames_written`=20.
- Out-of-range header 0x00000014 followed by two words:
  - Required: `err`=1; no strobe; `FrameData` unchanged; `clear` restores IDLE with `err`=0.
- `reset` asserted after the header and first data word:
  - Required: next cycle all outputs at reset values; no strobe in the following 10 cycles.
- END header 0x80000000:
  - Required: `done`=1 and `s_ready`=0 until `clear`.
  - With MASK_EN and only frame 3 written: `err`=1 and `frames_mask`=20'h00008.
- Random `s_valid` gaps over 100 frames:
  - Required: strobe index, per-row data and the `frames_written` count all match a reference model.
